// File: rtl/serial_adder.sv
// serial_adder: multi-cycle LSB-first add/subtract, DIGIT bits per clock through a registered carry,
// with valid/ready handshakes on operand capture and result delivery.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, sa_q, sa_d, sb_q, sb_d;
  logic [DIGIT:0]   dig;
  logic [WIDTH-1:0] res_next;
  assign dig      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // new digit enters at the top; after N steps the LSB digit has reached bit 0
  assign res_next = WIDTH'({dig[DIGIT-1:0], res_q} >> DIGIT);
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = cin ^ sub;
      sa_d    = a[WIDTH-1];
      sb_d    = b[WIDTH-1] ^ sub;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      res_d   = res_next;
      carry_d = dig[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        state_d = DONE;
        sum_d   = res_next;
        cout_d  = dig[DIGIT];
        ovf_d   = (sa_q == sb_q) && (res_next[WIDTH-1] != sa_q);
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for WIDTH=8 with DIGIT=1 and DIGIT=4 instances.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 0, cout, overflow;
  logic [7:0] a = 0, b = 0, sum;
  logic in_valid4 = 0, in_ready4, cin4 = 0, sub4 = 0, out_valid4, out_ready4 = 0, cout4, overflow4;
  logic [7:0] a4 = 0, b4 = 0, sum4;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow));

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .overflow(overflow4));

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;
  vec_t v[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic run_op(input logic [7:0] oa, ob, input logic oc, os, output int lat);
    @(negedge clk);
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1;
    chk("in_ready_before_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, prev, nres;
    v[0] = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 0};
    v[1] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
    v[2] = '{8'h10, 8'h20, 1, 0, 8'h31, 0, 0};
    v[3] = '{8'h05, 8'h07, 0, 1, 8'hFE, 0, 0};
    v[4] = '{8'h80, 8'h01, 0, 1, 8'h7F, 1, 1};
    v[5] = '{8'h05, 8'h03, 1, 1, 8'h01, 1, 0};
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", {sum, cout, overflow}, 0);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, lat);
      chk($sformatf("latency[%0d]", i), lat, 8);
      chk($sformatf("sum[%0d]", i), sum, v[i].sum);
      chk($sformatf("cout[%0d]", i), cout, v[i].cout);
      chk($sformatf("overflow[%0d]", i), overflow, v[i].ovf);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk($sformatf("in_ready_after_done[%0d]", i), in_ready, 1);
    end
    // backpressure with operands scrambled during RUN
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 0; sub = 0; in_valid = 1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1; cin = 1;
      @(negedge clk);
    end
    lat = 4;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_sum_held", {sum, cout, overflow}, {8'h4B, 2'b00});
      chk("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_in_ready_after_release", in_ready, 1);
    chk("bp_out_valid_dropped", out_valid, 0);
    // reset at cnt=3
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 0; sub = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_sum", sum, 0);
    chk("midrun_rst_in_ready", in_ready, 0);
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) chk("no_pulse_after_rst", out_valid, 0);
    end
    chk("in_ready_after_midrun_rst", in_ready, 1);
    run_op(8'h12, 8'h34, 0, 0, lat);
    chk("fresh_latency", lat, 8);
    chk("fresh_sum", sum, 8'h46);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    // DIGIT=4 instance
    a4 = 8'hAB; b4 = 8'h55; in_valid4 = 1;
    chk("d4_in_ready", in_ready4, 1);
    @(negedge clk);
    in_valid4 = 0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("d4_latency", lat, 2);
    chk("d4_sum", sum4, 8'h00);
    chk("d4_cout", cout4, 1);
    out_ready4 = 1;
    @(negedge clk);
    a4 = 8'h11; b4 = 8'h22; in_valid4 = 1;
    prev = -1;
    nres = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid4) begin
        chk("d4_b2b_sum", sum4, 8'h33);
        if (prev >= 0) chk("d4_b2b_interval", c - prev, 4);
        prev = c;
        nres++;
      end
    end
    chk("d4_b2b_count", nres >= 6, 1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It processes DIGIT bits per clock through a registered carry, LSB-first, until the WIDTH-bit result is complete.
- Operands are captured with a valid/ready handshake on the input side. The result is presented with a valid/ready handshake on the output side.
- Intended for area-constrained datapaths where one full-adder slice per digit replaces a WIDTH-bit ripple adder.
- Supports add and subtract with carry/borrow-in, carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of RUN cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = a+b+cin; 1 = a−b−cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out; for sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; the internal bit counter and carry register clear.
  - out_valid, sum, cout and overflow all go to 0.
  - in_ready = 0 while rst is high, and 1 in the first cycle after release.
- FSM, three states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE) and !rst, driven combinationally from state. out_valid = (state==DONE), registered.
- IDLE:
  - On a rising edge with in_valid && in_ready: capture a into shift register A.
  - Capture b into shift register B; store it as ~b when sub=1.
  - Load the carry register with cin^sub, i.e. the sub case computes a + ~b + ~cin.
  - Latch sub and the operand sign bits, clear cnt, go to RUN.
- RUN, every edge:
  - Add the low DIGIT bits of A and B plus the carry register.
  - Shift the DIGIT result bits into the top of the result shift register.
  - Shift A and B right by DIGIT; update the carry register; cnt++.
  - On the edge where cnt reaches N−1 → DONE. sum is loaded with the full result, cout with the final carry, and overflow with (sA==sB') && (sum[MSB]!=sA), where sB' is the effective (inverted if sub) B sign bit.
  - Latency: out_valid rises exactly N cycles after the accept edge (WIDTH=8, DIGIT=1 → 8; DIGIT=4 → 2).
- DONE:
  - sum, cout and overflow are held stable.
  - On an edge with out_ready=1 → IDLE, so in_ready=1 the next cycle. If out_ready=0, the block stays in DONE indefinitely.
  - Throughput is one operation per N+2 cycles when out_ready is held at 1.
- Outputs sum/cout/overflow change only on entry to DONE. They keep the last result through IDLE and RUN.
- a, b, cin, sub and in_valid are ignored outside IDLE. Changes during RUN/DONE do not affect the result in progress.
- in_valid and out_ready are both allowed to be high in DONE. Only the output handshake completes there; new operands are accepted no earlier than the IDLE cycle.
- sub=1 with cin=1 computes a−b−1, with borrow chaining.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse appears.
- DIGIT not dividing WIDTH is illegal; an elaboration-time check stops the build.

Test Plan:
- WIDTH=8, DIGIT=1, add: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0; out_valid rises exactly 8 cycles after the accept edge.
- Add: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, overflow=1. With cin=1, a=0x10, b=0x20 → sum=0x31, cout=0, overflow=0.
- Sub: a=0x05, b=0x07, cin=0 → sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1. Then a=0x05, b=0x03, cin=1 → sum=0x01, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_valid and sum remain stable and in_ready stays 0. Raise out_ready → in_ready=1 the following cycle. Toggling a/b during RUN leaves the result unchanged.
- Reset mid-RUN (rst pulsed at cnt=3) → out_valid=0, sum=0, in_ready=1 after release. A fresh op 0x12+0x34 → 0x46.
- DIGIT=4, WIDTH=8: 0xAB+0x55 → sum=0x00, cout=1; latency 2 cycles. Back-to-back ops with out_ready=1 give one result every 4 cycles.
